fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), the if_instr value when the output slot is empty.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 stall  in  1  decode not accepting; hold the output slot.
REQ-006 redirect  in  1  taken branch/JAL/JALR resolved this cycle.
REQ-007 redirect_pc  in  32  target PC; bits [1:0] ignored, treated as 00.
REQ-008 imem_req  out  1  instruction memory request.
REQ-009 imem_addr  out  32  request word address, bits [1:0]=00.
REQ-010 imem_gnt  in  1  request accepted this cycle.
REQ-011 imem_rvalid  in  1  response valid; at most one outstanding request.
REQ-012 imem_rdata  in  32  response instruction.
REQ-013 if_valid  out  1  output slot holds a live instruction.
REQ-014 if_pc  out  32  PC of if_instr.
REQ-015 if_instr  out  32  fetched instruction.
REQ-016 if_opcode  out  7  if_instr[6:0], combinational, drives the control unit decoder input.

Function
REQ-017 FSM states: S_REQ (imem_req=1), S_WAIT (request granted, awaiting rvalid), S_FULL (response buffered, output slot blocked).
REQ-018 S_REQ: imem_addr=pc; imem_addr SHALL stay stable while imem_req=1 and imem_gnt=0; on imem_gnt latch req_pc=pc, go S_WAIT.
REQ-019 S_WAIT: imem_req=0; on imem_rvalid with drop=0 and slot free, load if_instr=imem_rdata, if_pc=req_pc, if_valid=1, pc=req_pc+4, go S_REQ.
REQ-020 Slot free means if_valid=0 or stall=0 in that cycle.
REQ-021 S_WAIT, rvalid, slot not free: capture imem_rdata/req_pc in a one-entry buffer, go S_FULL.
REQ-022 S_FULL: imem_req=0; when stall=0, move buffer to output slot, pc=buf_pc+4, go S_REQ.
REQ-023 stall=0 with no new instruction arriving SHALL clear if_valid and set if_instr=NOP_INSTR the next cycle.
REQ-024 stall=1 with if_valid=1: if_valid, if_pc, if_instr SHALL hold unchanged.
REQ-025 redirect=1 (highest priority, overrides stall): next cycle pc={redirect_pc[31:2],2'b00}, if_valid=0, if_instr=NOP_INSTR, buffer invalidated.
REQ-026 redirect in S_REQ without gnt: go S_REQ at new pc; with gnt same cycle: set drop=1, go S_WAIT.
REQ-027 redirect in S_WAIT: set drop=1, stay S_WAIT; response with drop=1 SHALL be discarded, drop cleared, go S_REQ at redirected pc.
REQ-028 redirect in S_FULL: discard buffer, go S_REQ.
REQ-029 redirect coincident with rvalid in S_WAIT: response discarded, go S_REQ at redirect target.
REQ-030 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 32'h0000_0000.
REQ-031 Latency: gnt in cycle N, rvalid in N+1 -> if_valid=1 in N+2; peak throughput one instruction per 2 cycles.
REQ-032 imem_rvalid in S_REQ or S_FULL SHALL be ignored.

Reset
REQ-033 rst_n=0 SHALL immediately force: pc=RESET_PC, state=S_REQ, drop=0, buffer empty, imem_req=0, if_valid=0, if_pc=0, if_instr=NOP_INSTR.
REQ-034 imem_req SHALL first assert in the first clock edge after rst_n deasserts; reset mid-request SHALL abandon it and later responses SHALL be ignored until a new grant.

Verification
REQ-035 Reset release, gnt immediate, rvalid next cycle, rdata=32'h0050_0093 -> if_pc=0, if_instr=32'h0050_0093, if_opcode=7'h13, then imem_addr=4.
REQ-036 Stall=1 for 3 cycles while if_valid=1 at pc 4 and next response arrives -> outputs hold pc 4; S_FULL; on stall=0 pc 8 instruction appears next cycle, no fetch lost.
REQ-037 Redirect to 32'h0000_0102 during S_WAIT -> pending response discarded, next imem_addr=32'h0000_0100, if_valid=0 until the new response.
REQ-038 Redirect and stall together with if_valid=1 -> if_valid=0 next cycle, if_instr=32'h0000_0013.
REQ-039 Redirect to 32'hFFFF_FFFC, fetch completes -> next imem_addr=32'h0000_0000.
REQ-040 gnt held low 5 cycles -> imem_req=1 and imem_addr constant throughout; rst_n pulse mid-wait -> imem_req=0 and all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, a one-entry response
// buffer for stalled decode, and redirect handling that drops in-flight responses.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [6:0]  if_opcode
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } state_t;

  function automatic logic [31:0] next_word(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] req_pc_r, req_pc_s;
  logic [31:0] buf_pc_r, buf_pc_s;
  logic [31:0] buf_instr_r, buf_instr_s;
  logic        drop_r, drop_s;
  logic        run_r;
  logic        if_valid_r, if_valid_s;
  logic [31:0] if_pc_r, if_pc_s;
  logic [31:0] if_instr_r, if_instr_s;
  logic        load_s;
  logic [31:0] load_pc_s, load_instr_s;
  logic        slot_free_s;
  logic        req_s;
  logic [31:0] target_s;

  // run_r keeps imem_req low until the first edge after reset release
  assign req_s       = (state_r == S_REQ) && run_r;
  assign slot_free_s = !if_valid_r || !stall;
  assign target_s    = redirect_pc & 32'hFFFF_FFFC;

  // Next-state, PC, buffer and output-slot selection
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    req_pc_s     = req_pc_r;
    drop_s       = drop_r;
    buf_pc_s     = buf_pc_r;
    buf_instr_s  = buf_instr_r;
    load_s       = 1'b0;
    load_pc_s    = req_pc_r;
    load_instr_s = imem_rdata;
    if_valid_s   = if_valid_r;
    if_pc_s      = if_pc_r;
    if_instr_s   = if_instr_r;

    if (redirect) begin
      pc_s = target_s;
    end else begin
      pc_s = pc_r;
    end

    case (state_r)
      S_REQ: begin
        if (req_s && imem_gnt) begin
          req_pc_s = pc_r;
          drop_s   = redirect;
          state_s  = S_WAIT;
        end else begin
          state_s = S_REQ;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          drop_s = 1'b0;
          if (redirect || drop_r) begin
            state_s = S_REQ;
          end else if (slot_free_s) begin
            load_s       = 1'b1;
            load_pc_s    = req_pc_r;
            load_instr_s = imem_rdata;
            pc_s         = next_word(req_pc_r);
            state_s      = S_REQ;
          end else begin
            buf_pc_s    = req_pc_r;
            buf_instr_s = imem_rdata;
            state_s     = S_FULL;
          end
        end else begin
          drop_s  = drop_r | redirect;
          state_s = S_WAIT;
        end
      end
      S_FULL: begin
        if (redirect) begin
          state_s = S_REQ;
        end else if (!stall) begin
          load_s       = 1'b1;
          load_pc_s    = buf_pc_r;
          load_instr_s = buf_instr_r;
          pc_s         = next_word(buf_pc_r);
          state_s      = S_REQ;
        end else begin
          state_s = S_FULL;
        end
      end
      default: begin
        state_s = S_REQ;
        drop_s  = 1'b0;
      end
    endcase

    // Redirect kills the slot even when decode is stalled
    if (redirect) begin
      if_valid_s = 1'b0;
      if_instr_s = NOP_INSTR;
    end else if (load_s) begin
      if_valid_s = 1'b1;
      if_pc_s    = load_pc_s;
      if_instr_s = load_instr_s;
    end else if (!stall) begin
      if_valid_s = 1'b0;
      if_instr_s = NOP_INSTR;
    end else begin
      if_valid_s = if_valid_r;
      if_instr_s = if_instr_r;
    end
  end

  // State and output-slot registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_REQ;
      pc_r        <= RESET_PC;
      req_pc_r    <= RESET_PC;
      drop_r      <= 1'b0;
      run_r       <= 1'b0;
      buf_pc_r    <= 32'd0;
      buf_instr_r <= NOP_INSTR;
      if_valid_r  <= 1'b0;
      if_pc_r     <= 32'd0;
      if_instr_r  <= NOP_INSTR;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      req_pc_r    <= req_pc_s;
      drop_r      <= drop_s;
      run_r       <= 1'b1;
      buf_pc_r    <= buf_pc_s;
      buf_instr_r <= buf_instr_s;
      if_valid_r  <= if_valid_s;
      if_pc_r     <= if_pc_s;
      if_instr_r  <= if_instr_s;
    end
  end

  assign imem_req  = req_s;
  assign imem_addr = pc_r;
  assign if_valid  = if_valid_r;
  assign if_pc     = if_pc_r;
  assign if_instr  = if_instr_r;
  assign if_opcode = if_instr_r[6:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed checks of the fetch unit's corner cases, then randomized traffic checked
// against a program-order stream scoreboard fed by a memory model.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n, stall, redirect, imem_gnt, imem_rvalid;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_pc, if_instr;
  logic [6:0]  if_opcode;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        gen_e;
  exp_t        mon_e;
  logic [31:0] gen_pc;
  bit          mon_en = 1'b0;
  int          consumed = 0;
  int          idle = 0;

  bit          pend;
  int          cnt;
  logic [31:0] pend_addr;

  fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_opcode(if_opcode)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic top_up();
    while (exp_q.size() < 8) begin
      gen_e.pc    = gen_pc;
      gen_e.instr = mem_word(gen_pc);
      exp_q.push_back(gen_e);
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  // Monitor: program-order stream, slot hold, request stability
  initial begin
    logic        p_req, p_gnt, p_redir, p_valid, p_stall;
    logic [31:0] p_addr, p_pc, p_instr;
    p_req = 1'b0; p_gnt = 1'b0; p_redir = 1'b0; p_valid = 1'b0; p_stall = 1'b0;
    p_addr = 32'd0; p_pc = 32'd0; p_instr = 32'd0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (p_req && !p_gnt && !p_redir) begin
          chk("req_held", 32'(imem_req), 32'd1);
          chk("addr_stable", imem_addr, p_addr);
        end
        if (p_valid && p_stall && !p_redir) begin
          chk("hold_valid", 32'(if_valid), 32'd1);
          chk("hold_pc", if_pc, p_pc);
          chk("hold_instr", if_instr, p_instr);
        end
        if (!if_valid) chk("empty_nop", if_instr, NOP);
        if (if_valid && !stall && !redirect) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL stream: no expected entry, got pc %h", if_pc);
          end else begin
            mon_e = exp_q.pop_front();
            chk("stream_pc", if_pc, mon_e.pc);
            chk("stream_instr", if_instr, mon_e.instr);
            chk("stream_opcode", 32'(if_opcode), 32'(mon_e.instr[6:0]));
          end
          consumed++;
          idle = 0;
        end else begin
          idle++;
        end
        if (idle > 200) begin
          n_cmp++;
          n_err++;
          $display("FAIL watchdog: %0d cycles without delivery, required <= 200", idle);
          idle = 0;
        end
        p_req = imem_req; p_gnt = imem_gnt; p_redir = redirect;
        p_valid = if_valid; p_stall = stall; p_addr = imem_addr;
        p_pc = if_pc; p_instr = if_instr;
      end
    end
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    step(); step();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_instr", if_instr, NOP);
    rst_n = 1'b1;
    step();
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'd0);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    chk("wait_noreq", 32'(imem_req), 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    step();
    imem_rvalid = 1'b0;
    chk("t1_valid", 32'(if_valid), 32'd1);
    chk("t1_pc", if_pc, 32'd0);
    chk("t1_instr", if_instr, 32'h0050_0093);
    chk("t1_opcode", 32'(if_opcode), 32'h13);
    chk("t1_next_addr", imem_addr, 32'd4);

    // Stall while the next response arrives
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    chk("drain_valid", 32'(if_valid), 32'd0);
    chk("drain_nop", if_instr, NOP);
    imem_rvalid = 1'b1; imem_rdata = mem_word(32'd4);
    step();
    imem_rvalid = 1'b0;
    chk("t2_pc", if_pc, 32'd4);
    chk("t2_addr", imem_addr, 32'd8);
    stall = 1'b1; imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = mem_word(32'd8);
    chk("stall1_pc", if_pc, 32'd4);
    step();
    imem_rvalid = 1'b0;
    chk("stall2_pc", if_pc, 32'd4);
    chk("stall2_instr", if_instr, mem_word(32'd4));
    chk("full_noreq", 32'(imem_req), 32'd0);
    step();
    chk("stall3_pc", if_pc, 32'd4);
    chk("stall3_valid", 32'(if_valid), 32'd1);
    stall = 1'b0;
    step();
    chk("unstall_pc", if_pc, 32'd8);
    chk("unstall_instr", if_instr, mem_word(32'd8));
    chk("unstall_addr", imem_addr, 32'd12);

    // Redirect during S_WAIT drops the pending response
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    step();
    redirect = 1'b0;
    chk("redir_valid", 32'(if_valid), 32'd0);
    chk("redir_noreq", 32'(imem_req), 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    chk("drop_valid", 32'(if_valid), 32'd0);
    chk("redir_addr", imem_addr, 32'h0000_0100);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = mem_word(32'h100);
    step();
    imem_rvalid = 1'b0;
    chk("redir_pc", if_pc, 32'h0000_0100);
    chk("redir_instr", if_instr, mem_word(32'h100));

    // Redirect with stall, then wrap at the top of memory
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    stall = 1'b0; redirect = 1'b0;
    chk("rs_valid", 32'(if_valid), 32'd0);
    chk("rs_instr", if_instr, 32'h0000_0013);
    chk("rs_addr", imem_addr, 32'hFFFF_FFFC);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = mem_word(32'hFFFF_FFFC);
    step();
    imem_rvalid = 1'b0;
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'h0000_0000);

    // Grant withheld, then reset mid-wait
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("gntlow_req", 32'(imem_req), 32'd1);
      chk("gntlow_addr", imem_addr, 32'd0);
    end
    rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_valid", 32'(if_valid), 32'd0);
    chk("arst_pc", if_pc, 32'd0);
    chk("arst_instr", if_instr, NOP);
    step();
    rst_n = 1'b1; stall = 1'b0;
    step();
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abandon_req", 32'(imem_req), 32'd0);
    step();
    rst_n = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0001;
    step();
    chk("stale_valid", 32'(if_valid), 32'd0);
    chk("stale_req", 32'(imem_req), 32'd1);
    step();
    imem_rvalid = 1'b0;
    chk("ignore_valid", 32'(if_valid), 32'd0);
    chk("ignore_addr", imem_addr, 32'd0);

    // Randomized traffic
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    step(); step();
    rst_n = 1'b1;
    pend = 1'b0; cnt = 0; pend_addr = 32'd0;
    exp_q.delete();
    gen_pc = 32'd0;
    top_up();
    step();
    mon_en = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (pend) begin
        if (cnt == 1) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend_addr);
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end else if ($urandom_range(0, 9) == 0) begin
        imem_rvalid = 1'b1;
      end
      imem_gnt = imem_req && ($urandom_range(0, 9) < 6);
      if (imem_gnt) begin
        pend = 1'b1;
        cnt = $urandom_range(1, 3);
        pend_addr = imem_addr;
      end
      stall    = ($urandom_range(0, 9) < 4);
      redirect = ($urandom_range(0, 19) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : 32'($urandom);
      if (redirect) begin
        exp_q.delete();
        gen_pc = redirect_pc & 32'hFFFF_FFFC;
      end
      top_up();
      step();
    end
    mon_en = 1'b0;
    n_cmp++;
    if (consumed < 100) begin
      n_err++;
      $display("FAIL progress: %0d instructions delivered, required >= 100", consumed);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
